// File: rtl/imem_responder_if.sv
// Instruction line-fill bus between icache (consumer) and memory (producer).
interface instruction_bus #(
  parameter int PHY_LEN = 32,
  parameter int ICLLEN  = 128
);
  logic              ldp;
  logic [PHY_LEN-1:0] addr;
  logic              ldr;
  logic [ICLLEN-1:0]  ldData;

  modport producer (
    input  ldp,
    input  addr,
    output ldr,
    output ldData
  );

  modport consumer (
    output ldp,
    output addr,
    input  ldr,
    input  ldData
  );
endinterface

// File: rtl/imem_responder.sv
// Memory-side line-fill responder with fixed latency and a
// word-granular program-load port into its line array.
module imem_responder #(
  parameter int MEM_LINES = 256,
  parameter int LATENCY   = 4,
  parameter int PHY_LEN   = 32,
  parameter int ICLLEN    = 128,
  parameter int INST_LEN  = 32
) (
  input  logic                clk,
  input  logic                rst,
  instruction_bus.producer    ibus,
  input  logic                prog_we,
  input  logic [PHY_LEN-1:0]  prog_addr,
  input  logic [INST_LEN-1:0] prog_data,
  output logic                busy,
  output logic                oor
);

  localparam int LIDX = $clog2(MEM_LINES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [PHY_LEN-1:0] addr_q, addr_d;
  logic               oor_q, oor_d;

  logic [ICLLEN-1:0]  mem_q [MEM_LINES];

  logic               req_oor;
  logic               prog_oor;
  logic [LIDX-1:0]    prog_idx;
  logic [1:0]         prog_word;
  logic [LIDX-1:0]    rd_idx;
  logic               unused_bits;

  assign req_oor   = |ibus.addr[PHY_LEN-1:LIDX+4];
  assign prog_oor  = |prog_addr[PHY_LEN-1:LIDX+4];
  assign prog_idx  = prog_addr[LIDX+3:4];
  assign prog_word = prog_addr[3:2];
  assign rd_idx    = addr_q[LIDX+3:4];

  assign unused_bits = ^{addr_q[3:0], prog_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
    end
  end

  // Image survives reset; only the load port changes it.
  always_ff @(posedge clk) begin
    if (prog_we && !prog_oor) begin
      mem_q[prog_idx][{prog_word, 5'b0} +: INST_LEN] <= prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    unique case (state_q)
      IDLE: begin
        if (ibus.ldp) begin
          addr_d = ibus.addr;
          oor_d  = req_oor;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = 8'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ibus.ldr    = 1'b0;
    ibus.ldData = '0;
    oor         = 1'b0;
    busy        = (state_q != IDLE);
    if (state_q == RESP) begin
      ibus.ldr = 1'b1;
      oor      = oor_q;
      if (!oor_q) begin
        ibus.ldData = mem_q[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed vector bench for imem_responder at latencies 4, 1 and 7.
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        ldp;
  logic [31:0] addr;
  int          sel;

  logic busy4, busy1, busy7;
  logic oor4, oor1, oor7;

  instruction_bus #(.PHY_LEN(32), .ICLLEN(128)) b4 ();
  instruction_bus #(.PHY_LEN(32), .ICLLEN(128)) b1 ();
  instruction_bus #(.PHY_LEN(32), .ICLLEN(128)) b7 ();

  assign b4.ldp  = ldp && (sel == 0);
  assign b1.ldp  = ldp && (sel == 1);
  assign b7.ldp  = ldp && (sel == 2);
  assign b4.addr = addr;
  assign b1.addr = addr;
  assign b7.addr = addr;

  imem_responder #(.MEM_LINES(256), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .ibus(b4),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .busy(busy4), .oor(oor4)
  );

  imem_responder #(.MEM_LINES(256), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .ibus(b1),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .busy(busy1), .oor(oor1)
  );

  imem_responder #(.MEM_LINES(256), .LATENCY(7)) u7 (
    .clk(clk), .rst(rst), .ibus(b7),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .busy(busy7), .oor(oor7)
  );

  logic         ldr_s, busy_s, oor_s;
  logic [127:0] data_s;

  always_comb begin
    case (sel)
      1: begin
        ldr_s = b1.ldr; data_s = b1.ldData;
        busy_s = busy1; oor_s = oor1;
      end
      2: begin
        ldr_s = b7.ldr; data_s = b7.ldData;
        busy_s = busy7; oor_s = oor7;
      end
      default: begin
        ldr_s = b4.ldr; data_s = b4.ldData;
        busy_s = busy4; oor_s = oor4;
      end
    endcase
  end

  localparam logic [127:0] L5 = {32'h00300193, 32'h00200113,
                                 32'h00100093, 32'h00000013};
  localparam logic [127:0] L0 = {32'h0000000D, 32'h0000000C,
                                 32'h0000000B, 32'h0000000A};
  localparam logic [127:0] L2 = {32'h22220003, 32'h22220002,
                                 32'h22220001, 32'h22220000};
  localparam logic [127:0] LF = {32'hFF000003, 32'hFF000002,
                                 32'hFF000001, 32'hFF000000};

  typedef struct {
    logic [31:0]  a;
    logic [127:0] d;
    logic         o;
  } vec_t;

  vec_t vt[7];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pwrite(input logic [31:0] a, input logic [31:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic pline(input int line, input logic [127:0] d);
    for (int w = 0; w < 4; w++)
      pwrite(32'(line * 16 + w * 4), d[w*32 +: 32]);
  endtask

  task automatic wait_ldr(output int n);
    n = 0;
    while (ldr_s !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic req(input string nm, input logic [31:0] a,
                     input int lat, input logic [127:0] d,
                     input logic o);
    int n;
    addr = a;
    ldp  = 1'b1;
    step();
    ldp  = 1'b0;
    chk({nm, " busy"}, 128'(busy_s), 128'(1));
    wait_ldr(n);
    chk({nm, " lat"}, 128'(n + 1), 128'(lat));
    chk({nm, " data"}, data_s, d);
    chk({nm, " oor"}, 128'(oor_s), 128'(o));
    step();
    chk({nm, " end"}, 128'({ldr_s, busy_s}), 128'(0));
  endtask

  task automatic held(input string nm, input int expn,
                      input int first_exp, input int per);
    int first;
    int cnt;
    int last;
    int gapbad;
    first = -1; cnt = 0; last = -1; gapbad = 0;
    addr = 32'h50;
    ldp  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ldr_s === 1'b1) begin
        if (first < 0) first = c;
        else if (c - last != per) gapbad++;
        last = c;
        cnt++;
      end
    end
    ldp = 1'b0;
    step();
    step();
    chk({nm, " first"}, 128'(first), 128'(first_exp));
    chk({nm, " pulses"}, 128'(cnt), 128'(expn));
    chk({nm, " gaps"}, 128'(gapbad), 128'(0));
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    ldp = 1'b0; addr = '0; sel = 0;
    vt[0] = '{32'h00050, L5, 1'b0};
    vt[1] = '{32'h10000, '0, 1'b1};
    vt[2] = '{32'h00000, L0, 1'b0};
    vt[3] = '{32'h00020, L2, 1'b0};
    vt[4] = '{32'h0005C, L5, 1'b0};
    vt[5] = '{32'h00FF0, LF, 1'b0};
    vt[6] = '{32'h01000, '0, 1'b1};

    step();
    step();
    chk("rst ldr", 128'(ldr_s), 128'(0));
    chk("rst busy", 128'(busy_s), 128'(0));
    chk("rst oor", 128'(oor_s), 128'(0));
    chk("rst data", data_s, '0);
    rst = 1'b1;

    pline(0, L0);
    pline(2, L2);
    pline(5, L5);
    pline(255, LF);
    pwrite(32'h10000, 32'hBADBAD00);

    for (int i = 0; i < 7; i++)
      req($sformatf("vec%0d", i), vt[i].a, 4, vt[i].d, vt[i].o);

    sel = 1;
    req("lat1", 32'h50, 1, L5, 1'b0);
    held("held1", 10, 1, 2);
    sel = 2;
    req("lat7", 32'h50, 7, L5, 1'b0);
    sel = 0;
    held("held4", 4, 4, 5);

    addr = 32'h20; ldp = 1'b1;
    step();
    ldp = 1'b0;
    pwrite(32'h24, 32'hDEADBEEF);
    wait_ldr(n);
    chk("wwait lat", 128'(n + 2), 128'(4));
    chk("wwait w1", 128'(data_s[63:32]), 128'(32'hDEADBEEF));
    chk("wwait w0", 128'(data_s[31:0]), 128'(32'h22220000));
    step();

    addr = 32'h20; ldp = 1'b1;
    step();
    ldp = 1'b0;
    wait_ldr(n);
    prog_addr = 32'h28; prog_data = 32'hCAFEF00D; prog_we = 1'b1;
    chk("wresp old", 128'(data_s[95:64]), 128'(32'h22220002));
    step();
    prog_we = 1'b0;
    req("refill", 32'h20, 4,
        {32'h22220003, 32'hCAFEF00D, 32'hDEADBEEF, 32'h22220000},
        1'b0);

    addr = 32'h50; ldp = 1'b1;
    step();
    step();
    ldp = 1'b0;
    wait_ldr(n);
    chk("drop lat", 128'(n + 2), 128'(4));
    chk("drop data", data_s, L5);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ldr_s === 1'b1) seen++;
    end
    chk("drop extra", 128'(seen), 128'(0));

    addr = 32'h50; ldp = 1'b1;
    step();
    ldp = 1'b0;
    step();
    #1 rst = 1'b0;
    #1;
    chk("rstw busy", 128'(busy_s), 128'(0));
    chk("rstw ldr", 128'(ldr_s), 128'(0));
    step();
    step();
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ldr_s === 1'b1 || busy_s === 1'b1) seen++;
    end
    chk("rstw none", 128'(seen), 128'(0));
    req("postrst", 32'h50, 4, L5, 1'b0);

    addr = 32'h10000; ldp = 1'b1;
    step();
    ldp = 1'b0;
    wait_ldr(n);
    #1 rst = 1'b0;
    #1;
    chk("rstr ldr", 128'(ldr_s), 128'(0));
    chk("rstr oor", 128'(oor_s), 128'(0));
    step();
    rst = 1'b1;
    req("postrst2", 32'h00, 4, L0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Memory-side responder for the `instruction_bus` interface. It serves the instruction cache's line-fill requests: it accepts a request on `ldp`, waits a programmable fixed latency, then returns one full `ICLLEN`-bit line on `ldData` with a one-cycle `ldr` pulse. It holds the instruction image in an internal line array. A word-granular program-load port lets the boot loader or bench write that image. The block sits between `icache` and the simulated/physical instruction memory, on the `producer` side of `instruction_bus`.

## Interface
- `MEM_LINES`, 256: number of `ICLLEN`-bit lines stored; power of two.
- `LATENCY`, 4: cycles from request acceptance to `ldr`; legal range 1..255.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; **asynchronous, active-low** (0 = reset asserted).
- `ibus`  `instruction_bus.producer`: reads `ibus.ldp` (1) and `ibus.addr` (`PHY_LEN`); drives `ibus.ldr` (1) and `ibus.ldData` (`ICLLEN`).
- `prog_we`  in  1  program-load word write strobe.
- `prog_addr`  in  `PHY_LEN`  byte address of the word to write; bits [1:0] ignored.
- `prog_data`  in  `INST_LEN`  word to write.
- `busy`  out  1  high while a request is in flight (WAIT or RESP).
- `oor`  out  1  one-cycle pulse, coincident with `ldr`, when the served line was out of range.

## Operation
- Address map:
  - `LIDX = $clog2(MEM_LINES)`.
  - Line index = `addr[LIDX+3:4]`.
  - Out of range ⇔ `addr[PHY_LEN-1:LIDX+4] != 0`.
  - `addr[3:0]` is ignored (the cache sends it as 0).
- Line layout matches the cache: word `w` (`addr[3:2]`) occupies `ldData[32*w+31:32*w]`.
- FSM states IDLE, WAIT, RESP:
  - IDLE: on `ldp`=1, latch `ibus.addr` into `addr_buf` and set the out-of-range flag. Go to RESP if `LATENCY`==1, else load counter with `LATENCY-1` and go to WAIT.
  - WAIT: decrement counter each cycle; when it reaches 1, go to RESP. `ibus.ldp` and `ibus.addr` are not sampled.
  - RESP: `ldr`=1 for exactly this cycle. `ldData` = `mem[index(addr_buf)]`, or all-zero if out of range. `oor` = out-of-range flag. Next state is always IDLE.
- A request is committed once accepted. Deasserting `ldp` during WAIT does not cancel it; the `ldr` pulse still occurs.
- Back-to-back requests: `ldp` is sampled again only in IDLE, so there is a minimum of one idle cycle between the `ldr` pulse and the next acceptance.
- Program writes:
  - `prog_we`=1 writes `prog_data` into word `prog_addr[3:2]` of line `prog_addr[LIDX+3:4]` at the clock edge.
  - Out-of-range `prog_addr` is dropped silently.
  - Writes are accepted in every state.
- Read/write ordering: RESP reads the array combinationally. A write committed at an edge before the RESP cycle is visible in `ldData`. A write in the RESP cycle itself is not visible in that response.
- Outside RESP, `ldData` = 0, `ldr` = 0, `oor` = 0.
- Array contents are not cleared by reset; they are only written by `prog_we`.

## Timing
- Reset values, applied immediately and asynchronously when `rst`=0:
  - state IDLE, counter 0, `addr_buf` 0, flag 0.
  - `ldr`=0, `ldData`=0, `busy`=0, `oor`=0.
- Reset asserted mid-WAIT or in RESP aborts the request with no `ldr` pulse. After `rst` returns to 1, the first acceptance is possible at the next edge.
- Latency: `ldp` sampled high in IDLE at edge k → `ldr`=1 during cycle k+`LATENCY` (the cycle after edge k+`LATENCY`-1).
- `busy` rises the cycle after acceptance and falls the cycle after RESP.
- `ldr`, `oor`, `busy` are decoded from registered state. There is no combinational path from `ldp` to `ldr`.

## Test plan
- Basic fill: program line 5 with words `0x00000013, 0x00100093, 0x00200113, 0x00300193` at addresses `0x50..0x5C`; assert `ldp` with `addr=0x00050` → `ldr` exactly 4 cycles later for 1 cycle, `ldData=0x00300193_00200113_00100093_00000013`, `oor`=0.
- Latency sweep: `LATENCY`=1 and 7 → `ldr` 1 and 7 cycles after acceptance; `ldp` held high continuously → one pulse per request, with a ≥1-cycle IDLE gap between pulses.
- Out of range: `addr=0x10000` (`MEM_LINES`=256) → `ldr` after 4 cycles with `ldData`=0 and `oor`=1; `prog_we` to `0x10000` leaves line 0 unchanged.
- Write during WAIT: request line 2, then `prog_we` word 1 of line 2 = `0xDEADBEEF` one cycle later → response carries `0xDEADBEEF` in bits [63:32]; the same write issued in the RESP cycle → old value returned, new value on the next fill.
- Abort and reset:
  - `ldp` dropped in WAIT → `ldr` still pulses on schedule.
  - `rst` pulled low in WAIT → `ldr`, `busy` go 0 immediately and no pulse follows.
  - New request after reset is served with full latency.
